// File: rtl/ledger_pkg.sv
// Purpose: shared record geometry, state encoding and byte-slice helpers for the ledger memory port.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ledger_pkg;

    localparam int RECORD_BYTES = 6;
    localparam int BYTE_W       = 8;
    localparam int REC_W        = RECORD_BYTES * BYTE_W;
    localparam int SEQ_W        = 3;

    // Field positions within a record; byte i lives at BASE_ADDR+i.
    localparam int P1_PRIV = 0;
    localparam int P1_PUB  = 1;
    localparam int P1_AMT  = 2;
    localparam int P2_PRIV = 3;
    localparam int P2_PUB  = 4;
    localparam int P2_AMT  = 5;

    localparam logic [SEQ_W-1:0] LAST_IDX = SEQ_W'(P2_AMT);

    localparam logic [2:0] ENC_IDLE       = 3'd0;
    localparam logic [2:0] ENC_LOAD       = 3'd1;
    localparam logic [2:0] ENC_LOAD_DRAIN = 3'd2;
    localparam logic [2:0] ENC_STORE      = 3'd3;
    localparam logic [2:0] ENC_FINISH     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ENC_IDLE,
        S_LOAD       = ENC_LOAD,
        S_LOAD_DRAIN = ENC_LOAD_DRAIN,
        S_STORE      = ENC_STORE,
        S_FINISH     = ENC_FINISH
    } state_t;

    // Byte i occupies [47-8i : 40-8i], so byte 0 is the most significant.
    function automatic logic [BYTE_W-1:0] rec_byte(input logic [REC_W-1:0] rec,
                                                   input logic [SEQ_W-1:0] idx);
        rec_byte = rec[(REC_W - 1) - BYTE_W * int'(idx) -: BYTE_W];
    endfunction

    function automatic logic [REC_W-1:0] rec_set_byte(input logic [REC_W-1:0]  rec,
                                                      input logic [SEQ_W-1:0]  idx,
                                                      input logic [BYTE_W-1:0] b);
        rec_set_byte = rec;
        rec_set_byte[(REC_W - 1) - BYTE_W * int'(idx) -: BYTE_W] = b;
    endfunction

endpackage

// File: rtl/ledger_byte_seq.sv
// Purpose: 3-bit record byte index; clear restarts at 0, step advances and holds at the last byte.
// Latency: index updates one edge after step; last is combinational from the index.
// Backpressure: none; the owner decides when to step.
// Ports: clock/resetn, clear (restart), step (advance), idx (current byte), last (idx is final byte).
module ledger_byte_seq
    import ledger_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             step,
    output logic [SEQ_W-1:0] idx,
    output logic             last
);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (step && !last) begin
            idx <= idx + SEQ_W'(1);
        end
    end

endmodule

// File: rtl/ledger_mem_port.sv
// Purpose: fetch / write back a 6-byte ledger record over a byte-wide synchronous RAM.
// Latency: load done at A+6+READ_LATENCY, store done at A+6 (A = acceptance edge).
// Backpressure: none; start requests seen while busy are dropped, not queued.
// Ports: clock/resetn; start_load/start_store/store_data from control; mem_* to the RAM;
//        memory_values (last fetched record), busy, done (one-cycle completion pulse).
module ledger_mem_port
    import ledger_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_W       = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start_load,
    input  logic              start_store,
    input  logic [REC_W-1:0]  store_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic [REC_W-1:0]  memory_values,
    output logic              busy,
    output logic              done
);

    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("ledger_mem_port: READ_LATENCY must be 1 or 2");
    end
    if (BASE_ADDR + RECORD_BYTES > (1 << ADDR_W)) begin : g_bad_base
        $error("ledger_mem_port: record does not fit in the address space");
    end

    state_t            state, state_nxt;
    logic [REC_W-1:0]  wr_shadow, wr_shadow_nxt;
    logic [REC_W-1:0]  rd_shadow, rd_shadow_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BYTE_W-1:0] wdata_nxt;
    logic              we_nxt;
    logic [SEQ_W-1:0]  iss_idx, cap_idx;
    logic              iss_last, cap_last;
    logic              seq_clear, iss_step, cap_en;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [SEQ_W-1:0] idx);
        addr_of = ADDR_W'(BASE_ADDR + int'(idx));
    endfunction

    // Both sequencers rest at 0 in IDLE so every operation starts from byte 0.
    assign seq_clear = (state == S_IDLE);
    assign iss_step  = (state == S_LOAD) || (state == S_STORE);

    ledger_byte_seq u_iss_seq (
        .clock  (clock),
        .resetn (resetn),
        .clear  (seq_clear),
        .step   (iss_step),
        .idx    (iss_idx),
        .last   (iss_last)
    );

    ledger_byte_seq u_cap_seq (
        .clock  (clock),
        .resetn (resetn),
        .clear  (seq_clear),
        .step   (cap_en),
        .idx    (cap_idx),
        .last   (cap_last)
    );

    // Every LOAD cycle issues one read; delaying that flag by the RAM latency
    // marks the cycle its byte is present on mem_rdata.
    if (READ_LATENCY == 2) begin : g_rl2
        logic [1:0] rd_pipe;
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) rd_pipe <= '0;
            else         rd_pipe <= {rd_pipe[0], (state == S_LOAD)};
        end
        assign cap_en = rd_pipe[1];
    end else begin : g_rl1
        logic rd_pipe;
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) rd_pipe <= 1'b0;
            else         rd_pipe <= (state == S_LOAD);
        end
        assign cap_en = rd_pipe;
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_of('0);
        wdata_nxt     = '0;
        we_nxt        = 1'b0;
        wr_shadow_nxt = wr_shadow;
        rd_shadow_nxt = cap_en ? rec_set_byte(rd_shadow, cap_idx, mem_rdata) : rd_shadow;
        case (state)
            S_IDLE: begin
                if (start_store) begin
                    // Byte 0 goes out straight from the input so the first write
                    // lands in the cycle right after acceptance.
                    state_nxt     = S_STORE;
                    wr_shadow_nxt = store_data;
                    we_nxt        = 1'b1;
                    wdata_nxt     = rec_byte(store_data, '0);
                end else if (start_load) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (iss_last) state_nxt = S_LOAD_DRAIN;
                else          addr_nxt  = addr_of(iss_idx + SEQ_W'(1));
            end
            S_LOAD_DRAIN: begin
                if (cap_en && cap_last) state_nxt = S_FINISH;
            end
            S_STORE: begin
                if (iss_last) begin
                    state_nxt = S_FINISH;
                end else begin
                    addr_nxt  = addr_of(iss_idx + SEQ_W'(1));
                    we_nxt    = 1'b1;
                    wdata_nxt = rec_byte(wr_shadow, iss_idx + SEQ_W'(1));
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_addr      <= addr_of('0);
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            memory_values <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_shadow     <= '0;
            rd_shadow     <= '0;
        end else begin
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_we    <= we_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_FINISH);
            wr_shadow <= wr_shadow_nxt;
            rd_shadow <= rd_shadow_nxt;
            // Publish the whole record at once, including the byte captured on this edge.
            if (state == S_LOAD_DRAIN && state_nxt == S_FINISH) begin
                memory_values <= rd_shadow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ledger_mem_port.sv
module tb_ledger_mem_port;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;

    logic        sl0, ss0, we0, busy0, done0;
    logic [47:0] sd0, mv0;
    logic [2:0]  addr0;
    logic [7:0]  wd0, rd0;

    logic        sl1, ss1, we1, busy1, done1;
    logic [47:0] sd1, mv1;
    logic [2:0]  addr1;
    logic [7:0]  wd1, rd1, rd1_p;

    logic       bk_we, bk_sel;
    logic [2:0] bk_addr;
    logic [7:0] bk_data;
    logic [7:0] ram0 [8];
    logic [7:0] ram1 [8];

    int vectors = 0;
    int miscompares = 0;

    logic [10:0] wq  [$];
    logic [47:0] mvq [$];

    ledger_mem_port #(.BASE_ADDR(0), .ADDR_W(3), .READ_LATENCY(1)) dut0 (
        .clock(clock), .resetn(resetn), .start_load(sl0), .start_store(ss0),
        .store_data(sd0), .mem_addr(addr0), .mem_wdata(wd0), .mem_we(we0),
        .mem_rdata(rd0), .memory_values(mv0), .busy(busy0), .done(done0)
    );

    ledger_mem_port #(.BASE_ADDR(2), .ADDR_W(3), .READ_LATENCY(2)) dut1 (
        .clock(clock), .resetn(resetn), .start_load(sl1), .start_store(ss1),
        .store_data(sd1), .mem_addr(addr1), .mem_wdata(wd1), .mem_we(we1),
        .mem_rdata(rd1), .memory_values(mv1), .busy(busy1), .done(done1)
    );

    always @(posedge clock) begin
        if (bk_we && !bk_sel) ram0[bk_addr] <= bk_data;
        else if (we0)         ram0[addr0]   <= wd0;
        rd0 <= ram0[addr0];
    end

    always @(posedge clock) begin
        if (bk_we && bk_sel) ram1[bk_addr] <= bk_data;
        else if (we1)        ram1[addr1]   <= wd1;
        rd1_p <= ram1[addr1];
        rd1   <= rd1_p;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write and every done pulse must match the next queued expectation.
    always @(negedge clock) begin : monitor
        logic [10:0] ew;
        if (resetn) begin
            if (we0) begin
                if (wq.size() == 0) check("wr_scoreboard_depth", 64'(wq.size()), 1);
                else begin
                    ew = wq.pop_front();
                    check("write_addr_data", {addr0, wd0}, ew);
                end
            end
            if (done0) begin
                if (mvq.size() == 0) check("done_scoreboard_depth", 64'(mvq.size()), 1);
                else check("done_memory_values", mv0, mvq.pop_front());
            end
        end
    end

    typedef struct {
        logic        st;
        logic        ld;
        logic        mid_ld;
        logic [47:0] sdata;
        logic [47:0] exp_mv;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    // Called at a negedge with dut0 idle; returns at the negedge of the cycle after done.
    task automatic run_vec(input vec_t v);
        ss0 = v.st;
        sl0 = v.ld;
        sd0 = v.sdata;
        if (v.st) begin
            for (int i = 0; i < 6; i++) wq.push_back({3'(i), v.sdata[47 - 8*i -: 8]});
        end
        mvq.push_back(v.exp_mv);
        @(negedge clock);
        ss0 = 1'b0;
        sl0 = 1'b0;
        for (int k = 0; k <= v.lat; k++) begin
            if (k > 0) @(negedge clock);
            if (k < 6) begin
                check("addr", addr0, 64'(k));
                check("we", we0, v.st);
            end
            check("busy", busy0, 1);
            check("done", done0, (k == v.lat));
            if (k == 2) begin
                sd0 = ~v.sdata;
                sl0 = v.mid_ld;
            end
            if (k == 3) sl0 = 1'b0;
        end
        @(negedge clock);
        check("busy_after", busy0, 0);
        check("done_after", done0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t rv;
        logic [7:0] b2;
        resetn = 1'b1;
        {sl0, ss0, sl1, ss1} = '0;
        sd0 = '0; sd1 = '0;
        bk_we = 1'b0; bk_sel = 1'b0; bk_addr = '0; bk_data = '0;
        #2 resetn = 1'b0;

        vecs[0] = '{st:1'b0, ld:1'b1, mid_ld:1'b1, sdata:48'h0,            exp_mv:48'h112233445566, lat:7};
        vecs[1] = '{st:1'b1, ld:1'b0, mid_ld:1'b1, sdata:48'hA1B2C3D4E5F6, exp_mv:48'h112233445566, lat:6};
        vecs[2] = '{st:1'b0, ld:1'b1, mid_ld:1'b0, sdata:48'h0,            exp_mv:48'hA1B2C3D4E5F6, lat:7};
        vecs[3] = '{st:1'b1, ld:1'b1, mid_ld:1'b0, sdata:48'h5A6B7C8D9EAF, exp_mv:48'hA1B2C3D4E5F6, lat:6};
        vecs[4] = '{st:1'b0, ld:1'b1, mid_ld:1'b1, sdata:48'h0,            exp_mv:48'h5A6B7C8D9EAF, lat:7};

        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bk_we = 1'b1; bk_sel = 1'b0; bk_addr = 3'(i); bk_data = 8'(8'h11 * (i + 1));
            @(negedge clock);
            bk_sel = 1'b1; bk_addr = 3'(i + 2); bk_data = 8'(i + 1);
        end
        @(negedge clock);
        bk_we = 1'b0;
        check("rst_addr0", addr0, 0);
        check("rst_wdata0", wd0, 0);
        check("rst_we0", we0, 0);
        check("rst_mv0", mv0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_addr1", addr1, 2);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during the third write of a store.
        ss0 = 1'b1;
        sd0 = 48'hC0C1C2C3C4C5;
        for (int i = 0; i < 6; i++) wq.push_back({3'(i), sd0[47 - 8*i -: 8]});
        @(negedge clock);
        ss0 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_we", we0, 0);
        check("midrst_mv", mv0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_addr", addr0, 0);
        @(negedge clock);
        #2 resetn = 1'b1;
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("postrst_we", we0, 0);
            check("postrst_done", done0, 0);
        end
        check("ram_b0", ram0[0], 8'hC0);
        check("ram_b1", ram0[1], 8'hC1);
        b2 = ram0[2];
        check("ram_b2_old_or_new", (b2 == 8'hC2 || b2 == 8'h7C), 1);
        check("ram_b3", ram0[3], 8'h8D);
        check("ram_b4", ram0[4], 8'h9E);
        check("ram_b5", ram0[5], 8'hAF);
        rv = '{st:1'b0, ld:1'b1, mid_ld:1'b0, sdata:48'h0,
               exp_mv:{8'hC0, 8'hC1, b2, 8'h8D, 8'h9E, 8'hAF}, lat:7};
        run_vec(rv);

        // Second instance: two-cycle RAM, record at addresses 2..7.
        sl1 = 1'b1;
        @(negedge clock);
        sl1 = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clock);
            if (k < 6) check("rl2_addr", addr1, 64'(k + 2));
            check("rl2_we", we1, 0);
            check("rl2_done", done1, (k == 8));
        end
        check("rl2_memory_values", mv1, 48'h010203040506);
        @(negedge clock);
        check("rl2_busy_after", busy1, 0);

        check("wr_scoreboard_empty", 64'(wq.size()), 0);
        check("done_scoreboard_empty", 64'(mvq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
